// File: rtl/maxpool_2x2.sv
// -----------------------------------------------------------------------------
// maxpool_2x2
//   Streaming 2x2 max-pooling (stride 2) over a raster-order frame of signed
//   fixed-point samples. Each even row folds column pairs into a half-width
//   line buffer. Each odd row combines its column pairs with the stored
//   partial maxima and emits one pooled sample per window through a
//   single-entry, back-pressurable output register.
//
//   Optional feature: define MAXPOOL_RELU_EN to clamp negative pooled results
//   to zero (fused ReLU). With the macro undefined, results pass unmodified.
//
//   Parameters
//     N      sample width (signed two's complement)
//     IMG_W  input row width in samples (even, >= 2)
//     IMG_H  input rows per frame (even, >= 2)
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous active-low reset
//     din         input sample, raster order
//     in_valid    din valid
//     in_ready    block can accept din this cycle
//     dout        pooled sample
//     out_valid   dout holds a pooled sample
//     out_ready   consumer accepts dout
//     frame_done  pulses during the transfer of the last pooled sample of a frame
// -----------------------------------------------------------------------------
module maxpool_2x2 #(
   parameter int N     = 16,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] din,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] dout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         frame_done
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LW = ((IMG_W / 2) > 1) ? $clog2(IMG_W / 2) : 1;

   // Signed maximum; ties return the (identical) value.
   function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [N-1:0]  r_pair;
   logic [N-1:0]  r_line [0:IMG_W/2-1];
   logic [N-1:0]  r_dout;
   logic          r_out_valid;
   logic          r_out_last;

   logic          w_accept;
   logic          w_col_odd;
   logic          w_row_odd;
   logic          w_col_last;
   logic          w_row_last;
   logic [LW-1:0] w_lb_idx;
   logic [N-1:0]  w_pair_max;
   logic [N-1:0]  w_pool_max;
   logic [N-1:0]  w_pool_final;
   logic          w_new_result;
   logic          w_frame_last;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_col_odd  = r_col[0];
   assign w_row_odd  = r_row[0];
   assign w_col_last = (r_col == CW'(IMG_W - 1));
   assign w_row_last = (r_row == RW'(IMG_H - 1));
   assign w_lb_idx   = LW'(r_col >> 1);

   assign w_pair_max = smax(r_pair, din);
   assign w_pool_max = smax(r_line[w_lb_idx], w_pair_max);

`ifdef MAXPOOL_RELU_EN
   assign w_pool_final = w_pool_max[N-1] ? {N{1'b0}} : w_pool_max;
`else
   assign w_pool_final = w_pool_max;
`endif

   // A pooled result is produced only by an accepted odd-row, odd-column sample.
   assign w_new_result = w_accept && w_col_odd && w_row_odd;
   assign w_frame_last = w_new_result && w_col_last && w_row_last;

   assign dout       = r_dout;
   assign out_valid  = r_out_valid;
   // The last-window tag travels with the output register, so the pulse lines
   // up with the actual handshake rather than with the producing input.
   assign frame_done = r_out_valid && out_ready && r_out_last;

   // Raster position counters and even-column pair register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col  <= {CW{1'b0}};
         r_row  <= {RW{1'b0}};
         r_pair <= {N{1'b0}};
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col <= {CW{1'b0}};
            if (w_row_last) begin
               r_row <= {RW{1'b0}};
            end else begin
               r_row <= r_row + RW'(1);
            end
         end else begin
            r_col <= r_col + CW'(1);
         end
         if (!w_col_odd) begin
            r_pair <= din;
         end
      end
   end

   // Line buffer of per-pair maxima from the even row; no reset needed since
   // every entry is rewritten on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (w_accept && w_col_odd && !w_row_odd) begin
         r_line[w_lb_idx] <= w_pair_max;
      end
   end

   // Single-entry output register with valid/ready handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout      <= {N{1'b0}};
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_new_result) begin
         // Can only happen when the register is empty or draining this cycle.
         r_dout      <= w_pool_final;
         r_out_valid <= 1'b1;
         r_out_last  <= w_frame_last;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

endmodule

// File: doc/maxpool_2x2.md
MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 Parameter N, default 16: sample width; signed Q8.8 two's complement.
REQ-002 Parameter IMG_W, default 28: input row width in samples; even, >=2.
REQ-003 Parameter IMG_H, default 28: input rows per frame; even, >=2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 din  input  N  signed input sample, raster order (row-major, column 0 first).
REQ-007 in_valid  input  1  din is valid this cycle.
REQ-008 in_ready  output  1  block accepts din this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-009 dout  output  N  signed pooled sample.
REQ-010 out_valid  output  1  dout holds a pooled sample.
REQ-011 out_ready  input  1  consumer accepts dout; an output transfer occurs when out_valid and out_ready are both high.
REQ-012 frame_done  output  1  one-cycle pulse when the last pooled sample of a frame transfers out.

Function
REQ-013 Block computes the signed maximum of each non-overlapping 2x2 window; output frame is IMG_W/2 x IMG_H/2, raster order.
REQ-014 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance only on accepted input; column wraps to 0 and increments row; row wraps to 0 after IMG_H-1, column IMG_W-1.
REQ-015 Even row, odd column: max(previous even-column sample, din) is written to line buffer entry col/2 (IMG_W/2 entries of N bits).
REQ-016 Odd row, odd column: max(line buffer entry col/2, previous even-column sample, din) is loaded into the output register and out_valid is set on the next rising edge (latency 1 cycle from the accepting edge).
REQ-017 Even-column samples are held in a single N-bit pair register until the odd-column partner arrives.
REQ-018 All comparisons are signed; equal values produce that value; no saturation or rounding; dout width equals N.
REQ-019 in_ready = !out_valid || out_ready (single-entry output register; no loss or duplication under backpressure).
REQ-020 Output transfer with no new pooled result that cycle clears out_valid; transfer with a simultaneous new result keeps out_valid high and loads the new value.
REQ-021 dout holds its value while out_valid is high and out_ready is low.
REQ-022 frame_done is asserted in the cycle where the output transfer of pooled window (IMG_H/2-1, IMG_W/2-1) occurs.
REQ-023 A new frame starts immediately after the last input of the previous frame; no idle cycle required.

Reset
REQ-024 While reset is low: column and row counters = 0, pair register = 0, out_valid = 0, dout = 0, frame_done = 0.
REQ-025 in_ready = 1 after reset deasserts (out_valid = 0).
REQ-026 Line buffer contents need not be cleared; they are always written on even rows before being read.
REQ-027 Reset asserted mid-frame discards the partial frame; the first sample accepted after release is row 0, column 0.

Configuration
REQ-028 Macro MAXPOOL_RELU_EN defined: pooled result below zero is replaced by 0 before loading the output register (fused ReLU).
REQ-029 MAXPOOL_RELU_EN undefined: pooled result passes unmodified, negative values included.

Verification (IMG_W=4, IMG_H=2 unless stated; values in Q8.8 hex)
REQ-030 Rows {0300,0700,0100,0200},{0500,0200,0800,0400}, out_ready=1 -> dout 0700 then 0800, each one cycle after its odd-row odd-column input; frame_done with the second.
REQ-031 All-negative window {FF00,FE00},{FD00,FC00} -> dout FF00 without MAXPOOL_RELU_EN; 0000 with it.
REQ-032 out_ready held low after first output -> in_ready drops, dout stays 0700, no samples lost; release -> 0800 follows once.
REQ-033 in_valid toggled randomly over two back-to-back frames -> identical output sequence, two frame_done pulses.
REQ-034 reset pulsed low after 5 accepted samples -> out_valid=0 immediately; next full frame pools correctly from row 0, column 0.
REQ-035 IMG_W=28, IMG_H=28 random frame vs. reference model -> 196 outputs match, exactly one frame_done.
